// File: rtl/qpsk_prbs_checker_pkg.sv
// Shared definitions for the QPSK m-sequence checker: FSM encoding, LFSR width
// and small arithmetic helpers used by both channel and top.
package qpsk_prbs_checker_pkg;

    localparam int LFSR_W = 5;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } chk_state_e;

    function automatic logic lfsr_pred(input logic [LFSR_W-1:0] s, input logic [LFSR_W-1:0] taps);
        return ^(s & taps);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/qpsk_prbs_checker_ch.sv
// One checker channel: self-synchronising LFSR with HUNT/VERIFY/LOCK tracking,
// windowed loss-of-lock detection and a saturating error counter.
module qpsk_prbs_chk_ch
    import qpsk_prbs_checker_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TYPE     = 5'b10100,
    parameter int                SYNC_N   = 16,
    parameter int                WIN      = 32,
    parameter int                LOSS_ERR = 4
) (
    input  logic        CLK_50MHZ,
    input  logic        RST,
    input  logic        sym_valid,
    input  logic        rx_bit,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt
);

    localparam logic [2:0] HUNT_LAST = 3'(LFSR_W - 1);
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_N - 1);
    localparam logic [7:0] WIN_LAST  = 8'(WIN - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_ERR - 1);

    chk_state_e        state_r, state_nxt_s;
    logic [LFSR_W-1:0] lfsr_r, lfsr_nxt_s;
    logic [2:0]        hunt_cnt_r, hunt_nxt_s;
    logic [7:0]        match_cnt_r, match_nxt_s;
    logic [7:0]        win_cnt_r, win_nxt_s;
    logic [7:0]        win_err_r, win_err_nxt_s;
    logic [15:0]       err_cnt_r, err_cnt_nxt_s;
    logic              err_pulse_r, err_pulse_nxt_s;
    logic              locked_r;
    logic              pred_s, miss_s;

    assign pred_s    = lfsr_pred(lfsr_r, TYPE);
    assign miss_s    = rx_bit ^ pred_s;
    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_cnt   = err_cnt_r;

    // FSM state register
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state_r  <= ST_HUNT;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            locked_r <= (state_nxt_s == ST_LOCK);
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        if (sym_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (hunt_cnt_r == HUNT_LAST) state_nxt_s = ST_VERIFY;
                    else                         state_nxt_s = ST_HUNT;
                end
                ST_VERIFY: begin
                    if (miss_s)                           state_nxt_s = ST_HUNT;
                    else if (match_cnt_r == SYNC_LAST)    state_nxt_s = ST_LOCK;
                    else                                  state_nxt_s = ST_VERIFY;
                end
                ST_LOCK: begin
                    // the error that reaches the window limit drops lock on the same symbol
                    if (miss_s && (win_err_r == LOSS_LAST)) state_nxt_s = ST_HUNT;
                    else                                    state_nxt_s = ST_LOCK;
                end
                default: state_nxt_s = ST_HUNT;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // LFSR, counters and error strobe next values
    always_comb begin
        lfsr_nxt_s      = lfsr_r;
        hunt_nxt_s      = hunt_cnt_r;
        match_nxt_s     = match_cnt_r;
        win_nxt_s       = win_cnt_r;
        win_err_nxt_s   = win_err_r;
        err_cnt_nxt_s   = err_cnt_r;
        err_pulse_nxt_s = 1'b0;
        if (sym_valid) begin
            case (state_r)
                ST_HUNT: begin
                    lfsr_nxt_s = {lfsr_r[LFSR_W-2:0], rx_bit};
                    if (hunt_cnt_r == HUNT_LAST) begin
                        hunt_nxt_s  = 3'd0;
                        match_nxt_s = 8'd0;
                    end else begin
                        hunt_nxt_s  = hunt_cnt_r + 3'd1;
                    end
                end
                ST_VERIFY: begin
                    lfsr_nxt_s = {lfsr_r[LFSR_W-2:0], pred_s};
                    if (miss_s) begin
                        hunt_nxt_s = 3'd0;
                    end else if (match_cnt_r == SYNC_LAST) begin
                        match_nxt_s   = 8'd0;
                        win_nxt_s     = 8'd0;
                        win_err_nxt_s = 8'd0;
                    end else begin
                        match_nxt_s = match_cnt_r + 8'd1;
                    end
                end
                ST_LOCK: begin
                    lfsr_nxt_s = {lfsr_r[LFSR_W-2:0], pred_s};
                    if (miss_s) begin
                        err_pulse_nxt_s = 1'b1;
                        err_cnt_nxt_s   = sat_inc16(err_cnt_r);
                        win_err_nxt_s   = win_err_r + 8'd1;
                        hunt_nxt_s      = 3'd0;
                    end else begin
                        err_pulse_nxt_s = 1'b0;
                    end
                    if (win_cnt_r == WIN_LAST) begin
                        win_nxt_s     = 8'd0;
                        win_err_nxt_s = 8'd0;
                    end else begin
                        win_nxt_s     = win_cnt_r + 8'd1;
                    end
                end
                default: begin
                    lfsr_nxt_s = lfsr_r;
                end
            endcase
        end else begin
            err_pulse_nxt_s = 1'b0;
        end
        if (clr_cnt) err_cnt_nxt_s = 16'd0;
        else         err_cnt_nxt_s = err_cnt_nxt_s;
    end

    // datapath registers
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            lfsr_r      <= '0;
            hunt_cnt_r  <= 3'd0;
            match_cnt_r <= 8'd0;
            win_cnt_r   <= 8'd0;
            win_err_r   <= 8'd0;
            err_cnt_r   <= 16'd0;
            err_pulse_r <= 1'b0;
        end else begin
            lfsr_r      <= lfsr_nxt_s;
            hunt_cnt_r  <= hunt_nxt_s;
            match_cnt_r <= match_nxt_s;
            win_cnt_r   <= win_nxt_s;
            win_err_r   <= win_err_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
            err_pulse_r <= err_pulse_nxt_s;
        end
    end

endmodule

// File: rtl/qpsk_prbs_checker.sv
// Two-channel QPSK m-sequence checker: independent I/Q channel trackers plus
// a saturating count of symbols received while both channels are locked.
module qpsk_prbs_checker
    import qpsk_prbs_checker_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TYPE_I   = 5'b10100,
    parameter logic [LFSR_W-1:0] TYPE_Q   = 5'b10100,
    parameter int                SYNC_N   = 16,
    parameter int                WIN      = 32,
    parameter int                LOSS_ERR = 4
) (
    input  logic        CLK_50MHZ,
    input  logic        RST,
    input  logic        sym_valid,
    input  logic [1:0]  sym,
    input  logic        clr_cnt,
    output logic        locked_i,
    output logic        locked_q,
    output logic [1:0]  err_pulse,
    output logic [15:0] err_cnt_i,
    output logic [15:0] err_cnt_q,
    output logic [31:0] bit_cnt
);

    logic        pulse_i_s, pulse_q_s;
    logic [31:0] bit_cnt_r, bit_cnt_nxt_s;

    qpsk_prbs_chk_ch #(.TYPE(TYPE_I), .SYNC_N(SYNC_N), .WIN(WIN), .LOSS_ERR(LOSS_ERR)) u_ch_i (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .sym_valid (sym_valid),
        .rx_bit    (sym[1]),
        .clr_cnt   (clr_cnt),
        .locked    (locked_i),
        .err_pulse (pulse_i_s),
        .err_cnt   (err_cnt_i)
    );

    qpsk_prbs_chk_ch #(.TYPE(TYPE_Q), .SYNC_N(SYNC_N), .WIN(WIN), .LOSS_ERR(LOSS_ERR)) u_ch_q (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .sym_valid (sym_valid),
        .rx_bit    (sym[0]),
        .clr_cnt   (clr_cnt),
        .locked    (locked_q),
        .err_pulse (pulse_q_s),
        .err_cnt   (err_cnt_q)
    );

    assign err_pulse = {pulse_i_s, pulse_q_s};
    assign bit_cnt   = bit_cnt_r;

    // bit counter next value; clear overrides a coincident increment
    always_comb begin
        bit_cnt_nxt_s = bit_cnt_r;
        if (clr_cnt)                                bit_cnt_nxt_s = 32'd0;
        else if (sym_valid && locked_i && locked_q) bit_cnt_nxt_s = sat_inc32(bit_cnt_r);
        else                                        bit_cnt_nxt_s = bit_cnt_r;
    end

    // bit counter register
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) bit_cnt_r <= 32'd0;
        else     bit_cnt_r <= bit_cnt_nxt_s;
    end

endmodule

// File: tb/tb_qpsk_prbs_checker.sv
// Randomised and directed bench for qpsk_prbs_checker against a sequence-level
// reference model built from the m-sequence recurrence a[n] = a[n-3] ^ a[n-5].
module tb_qpsk_prbs_checker;

    localparam int SYNC_N   = 16;
    localparam int WIN      = 32;
    localparam int LOSS_ERR = 4;

    logic        CLK_50MHZ = 1'b0;
    logic        RST       = 1'b1;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym       = 2'b00;
    logic        clr_cnt   = 1'b0;
    logic        locked_i, locked_q;
    logic [1:0]  err_pulse;
    logic [15:0] err_cnt_i, err_cnt_q;
    logic [31:0] bit_cnt;

    int vectors     = 0;
    int miscompares = 0;

    qpsk_prbs_checker #(
        .TYPE_I(5'b10100), .TYPE_Q(5'b10100),
        .SYNC_N(SYNC_N), .WIN(WIN), .LOSS_ERR(LOSS_ERR)
    ) dut (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .sym_valid (sym_valid),
        .sym       (sym),
        .clr_cnt   (clr_cnt),
        .locked_i  (locked_i),
        .locked_q  (locked_q),
        .err_pulse (err_pulse),
        .err_cnt_i (err_cnt_i),
        .err_cnt_q (err_cnt_q),
        .bit_cnt   (bit_cnt)
    );

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    // source sequences and model histories, index 0 oldest .. 4 newest
    int     src [2][5];
    int     hist[2][5];
    int     mode[2];   // 0 hunting, 1 verifying, 2 locked
    int     cnt[2], wpos[2], werr[2], errs[2], mpulse[2];
    longint mbits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 5; k++) hist[c][k] = 0;
            mode[c] = 0; cnt[c] = 0; wpos[c] = 0; werr[c] = 0; errs[c] = 0; mpulse[c] = 0;
        end
        mbits = 0;
    endtask

    task automatic push(input int c, input int v);
        for (int k = 0; k < 4; k++) hist[c][k] = hist[c][k+1];
        hist[c][4] = v;
    endtask

    task automatic m_chan(input int c, input int r);
        int p;
        p = hist[c][0] ^ hist[c][2];
        if (mode[c] == 0) begin
            push(c, r);
            cnt[c]++;
            if (cnt[c] == 5) begin mode[c] = 1; cnt[c] = 0; end
        end else if (mode[c] == 1) begin
            push(c, p);
            if (r != p) begin
                mode[c] = 0; cnt[c] = 0;
            end else begin
                cnt[c]++;
                if (cnt[c] == SYNC_N) begin mode[c] = 2; wpos[c] = 0; werr[c] = 0; end
            end
        end else begin
            push(c, p);
            wpos[c]++;
            if (r != p) begin
                mpulse[c] = 1;
                if (errs[c] < 65535) errs[c]++;
                werr[c]++;
            end
            if (werr[c] == LOSS_ERR) begin mode[c] = 0; cnt[c] = 0; end
            if (wpos[c] == WIN) begin wpos[c] = 0; werr[c] = 0; end
        end
    endtask

    function automatic int next_src(input int c);
        int b;
        b = src[c][0] ^ src[c][2];
        for (int k = 0; k < 4; k++) src[c][k] = src[c][k+1];
        src[c][4] = b;
        return b;
    endfunction

    // drive one cycle, let the DUT sample it, then advance the model
    task automatic step(input bit v, input bit fi, input bit fq, input bit clr);
        bit both;
        int bi, bq;
        if (v) begin
            bi = next_src(0) ^ int'(fi);
            bq = next_src(1) ^ int'(fq);
            sym = {bi[0], bq[0]};
        end else begin
            sym = 2'($urandom_range(3, 0));
        end
        sym_valid = v;
        clr_cnt   = clr;
        @(posedge CLK_50MHZ);
        both = (mode[0] == 2) && (mode[1] == 2);
        mpulse[0] = 0; mpulse[1] = 0;
        if (v) begin
            m_chan(0, int'(sym[1]));
            m_chan(1, int'(sym[0]));
            if (both && mbits < 64'hFFFF_FFFF) mbits++;
        end
        if (clr) begin errs[0] = 0; errs[1] = 0; mbits = 0; end
        #1;
    endtask

    task automatic clean(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pin_zero(input string tag);
        chk({tag, "_locked_i"}, 32'(locked_i), 32'd0);
        chk({tag, "_locked_q"}, 32'(locked_q), 32'd0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_err_cnt_i"}, 32'(err_cnt_i), 32'd0);
        chk({tag, "_err_cnt_q"}, 32'(err_cnt_q), 32'd0);
        chk({tag, "_bit_cnt"}, bit_cnt, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge CLK_50MHZ); #1;
        sym_valid = 1'b0; clr_cnt = 1'b0;
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK_50MHZ);
        #3 RST = 1'b0;
    endtask

    // per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge CLK_50MHZ);
            chk("locked_i", 32'(locked_i), 32'(mode[0] == 2));
            chk("locked_q", 32'(locked_q), 32'(mode[1] == 2));
            chk("err_pulse", 32'(err_pulse), 32'(mpulse[0] * 2 + mpulse[1]));
            chk("err_cnt_i", 32'(err_cnt_i), 32'(errs[0]));
            chk("err_cnt_q", 32'(err_cnt_q), 32'(errs[1]));
            chk("bit_cnt", bit_cnt, 32'(mbits));
        end
    end

    initial begin
        logic [4:0] seed_i, seed_q;
        int nvalid, iter;
        seed_i = 5'b10101;
        seed_q = 5'b00111;
        for (int k = 0; k < 5; k++) begin
            src[0][k] = int'(seed_i[4-k]);
            src[1][k] = int'(seed_q[4-k]);
        end
        model_reset();
        #1 pin_zero("reset");
        repeat (2) @(posedge CLK_50MHZ);
        #3 RST = 1'b0;

        // clean lock-up: lock on valid symbol 21
        clean(20);
        chk("pre_lock_i", 32'(locked_i), 32'd0);
        chk("pre_lock_q", 32'(locked_q), 32'd0);
        clean(1);
        chk("lock_i_21", 32'(locked_i), 32'd1);
        chk("lock_q_21", 32'(locked_q), 32'd1);
        clean(9);
        chk("bit_cnt_30", bit_cnt, 32'd9);
        chk("err_cnt_i_clean", 32'(err_cnt_i), 32'd0);

        // single I error while locked (symbol 31)
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("single_pulse", 32'(err_pulse), 32'd2);
        chk("single_cnt_i", 32'(err_cnt_i), 32'd1);
        chk("single_cnt_q", 32'(err_cnt_q), 32'd0);
        chk("single_lock_i", 32'(locked_i), 32'd1);
        clean(1);
        chk("pulse_clears", 32'(err_pulse), 32'd0);

        // window wraps on symbol 53; four errors on 54..57 drop I lock
        clean(21);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("burst3_lock_i", 32'(locked_i), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("burst4_lock_i", 32'(locked_i), 32'd0);
        chk("burst4_cnt_i", 32'(err_cnt_i), 32'd5);
        chk("burst4_bit_cnt", bit_cnt, 32'd36);
        chk("burst4_lock_q", 32'(locked_q), 32'd1);
        clean(20);
        chk("relock20_i", 32'(locked_i), 32'd0);
        clean(1);
        chk("relock21_i", 32'(locked_i), 32'd1);
        chk("frozen_bit_cnt", bit_cnt, 32'd36);

        // reset mid-lock takes effect without a clock edge
        #2 RST = 1'b1;
        model_reset();
        #1 pin_zero("midlock_rst");
        repeat (2) @(posedge CLK_50MHZ);
        #3 RST = 1'b0;
        nvalid = 0;
        iter = 0;
        while (nvalid < 20 && iter < 400) begin
            if ($urandom_range(1, 0) == 1) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                nvalid++;
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
            end
            iter++;
        end
        chk("gappy_budget", 32'(nvalid), 32'd20);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gappy_lock20", 32'(locked_i), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("gappy_lock21_i", 32'(locked_i), 32'd1);
        chk("gappy_lock21_q", 32'(locked_q), 32'd1);

        // Q error during VERIFY on symbol 10
        do_reset();
        clean(9);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        clean(11);
        chk("vfy_lock_i", 32'(locked_i), 32'd1);
        chk("vfy_lock_q21", 32'(locked_q), 32'd0);
        clean(9);
        chk("vfy_lock_q30", 32'(locked_q), 32'd0);
        clean(1);
        chk("vfy_lock_q31", 32'(locked_q), 32'd1);
        chk("vfy_cnt_q", 32'(err_cnt_q), 32'd0);

        // clear coincident with an I error
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_pulse", 32'(err_pulse), 32'd2);
        chk("clr_cnt_i", 32'(err_cnt_i), 32'd0);
        chk("clr_bit_cnt", bit_cnt, 32'd0);
        clean(1);
        chk("post_clr_bit_cnt", bit_cnt, 32'd1);

        // randomised traffic with gaps, sparse errors and clears
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0,
                 $urandom_range(39, 0) == 0, $urandom_range(99, 0) == 0);
        end

        @(posedge CLK_50MHZ);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
